mc_control: RTL and testbench



---
 rtl/mc_ctl_pkg.sv | 58 +++++
 rtl/mc_bus_watchdog.sv | 45 ++++
 rtl/mc_control.sv | 177 +++++++++++++++++
 tb/tb_mc_control.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, states, mux selects.
// Latency: n/a (constants and a pure decode helper).
// Backpressure: n/a.
package mc_ctl_pkg;

    // RV32I major opcodes handled by the sequencer
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic       BUS_ADDR_PC     = 1'b0;
    localparam logic       BUS_ADDR_ALUOUT = 1'b1;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_ALU    = 2'd1;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd2;

    localparam logic [1:0] OUT_SEL_ALUOUT = 2'd0;
    localparam logic [1:0] OUT_SEL_IMM    = 2'd1;
    localparam logic [1:0] OUT_SEL_PC4    = 2'd2;
    localparam logic [1:0] OUT_SEL_BUS    = 2'd3;

    localparam logic       ALU_SRC1_RS1    = 1'b0;
    localparam logic       ALU_SRC1_OLD_PC = 1'b1;
    localparam logic       ALU_SRC2_RS2    = 1'b0;
    localparam logic       ALU_SRC2_IMM    = 1'b1;

    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_OP_IMM = 2'd1;
    localparam logic [1:0] ALU_OP_OP     = 2'd2;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd3;

    // True for every opcode the sequencer knows how to execute
    function automatic logic opc_known(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_bus_watchdog.sv
// Bus wait watchdog: counts request cycles without bus_ready, flags expiry, sticky bus_error.
// Latency: expire is combinational in the cycle the count sits at the limit; bus_error registers next edge.
// Backpressure: bus_ready in the expiry cycle wins and suppresses the error.
module mc_bus_watchdog #(
    parameter int BUS_TIMEOUT = 16,
    parameter int TMO_W       = $clog2(BUS_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic bus_ready,
    input  logic clear,
    output logic expire,
    output logic bus_error
);

    // A zero timeout still needs a 1-bit counter to keep the declarations legal
    localparam int CNT_W = (TMO_W > 0) ? TMO_W : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt;

    assign expire = (BUS_TIMEOUT != 0) && req && !bus_ready && (cnt == LAST);

    // Wait counter: restarts per bus phase and on every completed beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || bus_ready) begin
            cnt <= '0;
        end else if (req && (BUS_TIMEOUT != 0)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky error flag, only cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_error <= 1'b0;
        end else if (expire) begin
            bus_error <= 1'b1;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB over one ALU and one bus, sticky traps.
// Latency: 3-5 cycles per instruction with a zero-wait bus; each bus wait cycle adds one.
// Backpressure: bus strobes and address select hold until bus_ready; watchdog traps a stalled bus.
module mc_control
    import mc_ctl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16,
    parameter int TMO_W       = $clog2(BUS_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       bus_ready,
    input  logic       branch_taken,
    output logic       bus_read,
    output logic       bus_write,
    output logic       bus_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] out_sel,
    output logic       alu_src_1,
    output logic       alu_src_2,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       bus_error,
    output logic [2:0] state
);

    state_t state_q;
    state_t state_d;
    logic   wd_req;
    logic   wd_clear;
    logic   wd_expire;

    assign state = state_q;

    // Request seen by the watchdog, taken from the state so it does not loop through the output decode
    assign wd_req = (state_q == ST_FETCH) ||
                    ((state_q == ST_MEM) && ((opcode == OPC_LOAD) || (opcode == OPC_STORE)));

    // Each new bus phase starts with a fresh wait budget
    assign wd_clear = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

    mc_bus_watchdog #(
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (wd_req),
        .bus_ready (bus_ready),
        .clear     (wd_clear),
        .expire    (wd_expire),
        .bus_error (bus_error)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky illegal-opcode flag, captured while decoding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if ((state_q == ST_DECODE) && !opc_known(opcode)) begin
            illegal <= 1'b1;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d      = state_q;
        bus_read     = 1'b0;
        bus_write    = 1'b0;
        bus_addr_sel = BUS_ADDR_PC;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PC4;
        reg_write    = 1'b0;
        out_sel      = OUT_SEL_ALUOUT;
        alu_src_1    = ALU_SRC1_RS1;
        alu_src_2    = ALU_SRC2_RS2;
        alu_op       = ALU_OP_ADD;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                bus_read     = 1'b1;
                bus_addr_sel = BUS_ADDR_PC;
                if (bus_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_PC4;
                    state_d  = ST_DECODE;
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                // Speculative OLD_PC+IMM lands in ALUOUT for branches and JAL
                alu_src_1 = ALU_SRC1_OLD_PC;
                alu_src_2 = ALU_SRC2_IMM;
                alu_op    = ALU_OP_ADD;
                if (!opc_known(opcode)) begin
                    state_d = ST_TRAP;
                end else if ((opcode == OPC_LUI) || (opcode == OPC_AUIPC)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_2 = ALU_SRC2_IMM;
                        state_d   = ST_MEM;
                    end
                    OPC_OP_IMM: begin
                        alu_src_2 = ALU_SRC2_IMM;
                        alu_op    = ALU_OP_OP_IMM;
                        state_d   = ST_WB;
                    end
                    OPC_OP: begin
                        alu_op  = ALU_OP_OP;
                        state_d = ST_WB;
                    end
                    OPC_BRANCH: begin
                        alu_op   = ALU_OP_BRANCH;
                        pc_write = branch_taken;
                        pc_src   = PC_SRC_ALUOUT;
                        state_d  = ST_FETCH;
                    end
                    OPC_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_ALUOUT;
                        state_d  = ST_WB;
                    end
                    OPC_JALR: begin
                        alu_src_2 = ALU_SRC2_IMM;
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_ALU;
                        state_d   = ST_WB;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                bus_addr_sel = BUS_ADDR_ALUOUT;
                bus_read     = (opcode == OPC_LOAD);
                bus_write    = (opcode == OPC_STORE);
                if (bus_ready) begin
                    state_d = (opcode == OPC_LOAD) ? ST_WB : ST_FETCH;
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                case (opcode)
                    OPC_LOAD:          out_sel = OUT_SEL_BUS;
                    OPC_LUI:           out_sel = OUT_SEL_IMM;
                    OPC_JAL, OPC_JALR: out_sel = OUT_SEL_PC4;
                    default:           out_sel = OUT_SEL_ALUOUT;
                endcase
                state_d = ST_FETCH;
            end
            default: state_d = ST_TRAP;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       bus_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       bus_read, bus_write, bus_addr_sel, ir_write, pc_write, reg_write;
    logic       alu_src_1, alu_src_2, illegal, bus_error;
    logic [1:0] pc_src, out_sel, alu_op;
    logic [2:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    mc_control #(.BUS_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .bus_ready    (bus_ready),
        .branch_taken (branch_taken),
        .bus_read     (bus_read),
        .bus_write    (bus_write),
        .bus_addr_sel (bus_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .out_sel      (out_sel),
        .alu_src_1    (alu_src_1),
        .alu_src_2    (alu_src_2),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .bus_error    (bus_error),
        .state        (state)
    );

    always #5 clk = ~clk;

    // {state, rd, wr, addr_sel, ir_write, pc_write, pc_src, reg_write, out_sel, src1, src2, alu_op, illegal, bus_error}
    logic [18:0] obs;
    assign obs = {state, bus_read, bus_write, bus_addr_sel, ir_write, pc_write, pc_src,
                  reg_write, out_sel, alu_src_1, alu_src_2, alu_op, illegal, bus_error};

    function automatic logic [18:0] pk(input logic [2:0] st, input logic [4:0] bus5,
                                       input logic [1:0] pcs, input logic rw,
                                       input logic [1:0] osel, input logic [1:0] src,
                                       input logic [1:0] aop, input logic [1:0] flg);
        return {st, bus5, pcs, rw, osel, src, aop, flg};
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle, advance
    task automatic step(input logic rdy, input logic bt, input logic [18:0] exp, input string tag);
        bus_ready    = rdy;
        branch_taken = bt;
        #2;
        chk(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag, input logic [18:0] exp);
        rst_n     = 1'b0;
        bus_ready = 1'b0;
        #1;
        chk(tag, obs, exp);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [18:0] v_idle, v_fwait, v_fok, v_dec, v_ls_exe, v_mem_rd, v_mem_wr;
        logic [18:0] v_wb_alu, v_wb_bus, v_wb_pc4, v_wb_imm, v_trap_be, v_trap_ill;
        v_idle     = pk(S_IDLE,  5'b00000, 2'd0, 1'b0, 2'd0, 2'b00, 2'd0, 2'b00);
        v_fwait    = pk(S_FETCH, 5'b10000, 2'd0, 1'b0, 2'd0, 2'b00, 2'd0, 2'b00);
        v_fok      = pk(S_FETCH, 5'b10011, 2'd0, 1'b0, 2'd0, 2'b00, 2'd0, 2'b00);
        v_dec      = pk(S_DEC,   5'b00000, 2'd0, 1'b0, 2'd0, 2'b11, 2'd0, 2'b00);
        v_ls_exe   = pk(S_EXE,   5'b00000, 2'd0, 1'b0, 2'd0, 2'b01, 2'd0, 2'b00);
        v_mem_rd   = pk(S_MEM,   5'b10100, 2'd0, 1'b0, 2'd0, 2'b00, 2'd0, 2'b00);
        v_mem_wr   = pk(S_MEM,   5'b01100, 2'd0, 1'b0, 2'd0, 2'b00, 2'd0, 2'b00);
        v_wb_alu   = pk(S_WB,    5'b00000, 2'd0, 1'b1, 2'd0, 2'b00, 2'd0, 2'b00);
        v_wb_imm   = pk(S_WB,    5'b00000, 2'd0, 1'b1, 2'd1, 2'b00, 2'd0, 2'b00);
        v_wb_pc4   = pk(S_WB,    5'b00000, 2'd0, 1'b1, 2'd2, 2'b00, 2'd0, 2'b00);
        v_wb_bus   = pk(S_WB,    5'b00000, 2'd0, 1'b1, 2'd3, 2'b00, 2'd0, 2'b00);
        v_trap_be  = pk(S_TRAP,  5'b00000, 2'd0, 1'b0, 2'd0, 2'b00, 2'd0, 2'b01);
        v_trap_ill = pk(S_TRAP,  5'b00000, 2'd0, 1'b0, 2'd0, 2'b00, 2'd0, 2'b10);

        // Reset state while rst_n is low
        #2;
        chk("reset_state", obs, v_idle);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, v_idle, "idle_after_reset");

        // ADD with a zero-wait bus: FETCH, DECODE, EXEC, WB
        opcode = 7'b0110011;
        step(1'b1, 1'b0, v_fok, "add_fetch");
        step(1'b1, 1'b0, v_dec, "add_decode");
        step(1'b1, 1'b0, pk(S_EXE, 5'b00000, 2'd0, 1'b0, 2'd0, 2'b00, 2'd2, 2'b00), "add_exec");
        step(1'b1, 1'b0, v_wb_alu, "add_wb");

        // LW: two fetch waits, three MEM waits (the last one at the watchdog limit)
        opcode = 7'b0000011;
        step(1'b0, 1'b0, v_fwait, "lw_fetch_wait1");
        step(1'b0, 1'b0, v_fwait, "lw_fetch_wait2");
        step(1'b1, 1'b0, v_fok, "lw_fetch_ready");
        step(1'b0, 1'b0, v_dec, "lw_decode");
        step(1'b0, 1'b0, v_ls_exe, "lw_exec");
        step(1'b0, 1'b0, v_mem_rd, "lw_mem_wait1");
        step(1'b0, 1'b0, v_mem_rd, "lw_mem_wait2");
        step(1'b0, 1'b0, v_mem_rd, "lw_mem_wait3");
        step(1'b1, 1'b0, v_mem_rd, "lw_mem_ready");
        step(1'b1, 1'b0, v_wb_bus, "lw_wb");

        // BEQ taken then not taken, 3 cycles each
        opcode = 7'b1100011;
        step(1'b1, 1'b0, v_fok, "beq_t_fetch");
        step(1'b1, 1'b0, v_dec, "beq_t_decode");
        step(1'b1, 1'b1, pk(S_EXE, 5'b00001, 2'd2, 1'b0, 2'd0, 2'b00, 2'd3, 2'b00), "beq_t_exec");
        step(1'b1, 1'b0, v_fok, "beq_nt_fetch");
        step(1'b1, 1'b0, v_dec, "beq_nt_decode");
        step(1'b1, 1'b0, pk(S_EXE, 5'b00000, 2'd2, 1'b0, 2'd0, 2'b00, 2'd3, 2'b00), "beq_nt_exec");

        // JAL: PC from ALUOUT in EXEC, link value in WB
        opcode = 7'b1101111;
        step(1'b1, 1'b0, v_fok, "jal_fetch");
        step(1'b1, 1'b0, v_dec, "jal_decode");
        step(1'b1, 1'b0, pk(S_EXE, 5'b00001, 2'd2, 1'b0, 2'd0, 2'b00, 2'd0, 2'b00), "jal_exec");
        step(1'b1, 1'b0, v_wb_pc4, "jal_wb");

        // JALR: RS1+IMM straight from the ALU
        opcode = 7'b1100111;
        step(1'b1, 1'b0, v_fok, "jalr_fetch");
        step(1'b1, 1'b0, v_dec, "jalr_decode");
        step(1'b1, 1'b0, pk(S_EXE, 5'b00001, 2'd1, 1'b0, 2'd0, 2'b01, 2'd0, 2'b00), "jalr_exec");
        step(1'b1, 1'b0, v_wb_pc4, "jalr_wb");

        // LUI skips EXEC
        opcode = 7'b0110111;
        step(1'b1, 1'b0, v_fok, "lui_fetch");
        step(1'b1, 1'b0, v_dec, "lui_decode");
        step(1'b1, 1'b0, v_wb_imm, "lui_wb");

        // SW with bus_ready on the 4th MEM cycle: no error
        opcode = 7'b0100011;
        step(1'b1, 1'b0, v_fok, "sw_ok_fetch");
        step(1'b1, 1'b0, v_dec, "sw_ok_decode");
        step(1'b1, 1'b0, v_ls_exe, "sw_ok_exec");
        step(1'b0, 1'b0, v_mem_wr, "sw_ok_mem_wait1");
        step(1'b0, 1'b0, v_mem_wr, "sw_ok_mem_wait2");
        step(1'b0, 1'b0, v_mem_wr, "sw_ok_mem_wait3");
        step(1'b1, 1'b0, v_mem_wr, "sw_ok_mem_ready");

        // SW with bus_ready held low: TRAP after 4 MEM cycles
        step(1'b1, 1'b0, v_fok, "sw_to_fetch");
        step(1'b1, 1'b0, v_dec, "sw_to_decode");
        step(1'b1, 1'b0, v_ls_exe, "sw_to_exec");
        step(1'b0, 1'b0, v_mem_wr, "sw_to_mem1");
        step(1'b0, 1'b0, v_mem_wr, "sw_to_mem2");
        step(1'b0, 1'b0, v_mem_wr, "sw_to_mem3");
        step(1'b0, 1'b0, v_mem_wr, "sw_to_mem4");
        step(1'b1, 1'b1, v_trap_be, "sw_to_trap1");
        step(1'b1, 1'b1, v_trap_be, "sw_to_trap2");

        // Reset out of TRAP clears bus_error
        do_reset("reset_from_trap", v_idle);
        step(1'b0, 1'b0, v_idle, "idle_after_trap");

        // Illegal opcode 0000000
        opcode = 7'b0000000;
        step(1'b1, 1'b0, v_fok, "ill_fetch");
        step(1'b1, 1'b0, v_dec, "ill_decode");
        step(1'b1, 1'b1, v_trap_ill, "ill_trap1");
        step(1'b1, 1'b1, v_trap_ill, "ill_trap2");
        step(1'b0, 1'b0, v_trap_ill, "ill_trap3");

        do_reset("reset_clears_illegal", v_idle);
        step(1'b0, 1'b0, v_idle, "idle_after_illegal");

        // Reset pulsed during a MEM wait of LW
        opcode = 7'b0000011;
        step(1'b1, 1'b0, v_fok, "mid_fetch");
        step(1'b1, 1'b0, v_dec, "mid_decode");
        step(1'b0, 1'b0, v_ls_exe, "mid_exec");
        step(1'b0, 1'b0, v_mem_rd, "mid_mem_wait1");
        bus_ready = 1'b0;
        #1;
        chk("mid_mem_wait2", obs, v_mem_rd);
        do_reset("reset_mid_mem", v_idle);
        step(1'b0, 1'b0, v_idle, "idle_after_mid_reset");
        step(1'b0, 1'b0, v_fwait, "fetch_after_mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
